// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-port byte scheduler feeding a single UART transmitter.
// Each port buffers {last, data} in its own FIFO; the scheduler sends a
// header byte (A0 | port) followed by the frame body, one whole frame at a
// time, alternating ports when both have data waiting.
module uart_tx_sched #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in0_valid,
  input  logic [7:0] in0_data,
  input  logic       in0_last,
  input  logic       in1_valid,
  input  logic [7:0] in1_data,
  input  logic       in1_last,
  input  logic       uart_active,
  output logic [7:0] uart_d,
  output logic       uart_dv,
  output logic       grant,
  output logic       busy,
  output logic [1:0] ovf,
  output logic [7:0] drop0,
  output logic [7:0] drop1
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t     state;
  logic       dv_hist;
  logic       tx_ok;

  logic [1:0] in_valid;
  logic [7:0] in_data [2];
  logic [1:0] in_last;

  logic [8:0]  mem     [2][DEPTH];
  logic [AW:0] wr_ptr  [2];
  logic [AW:0] rd_ptr  [2];
  logic [8:0]  head    [2];
  logic [7:0]  drop_cnt[2];
  logic        ovf_r   [2];
  logic [1:0]  empty;
  logic [1:0]  full;
  logic [1:0]  push;
  logic [1:0]  pop;

  assign in_valid   = {in1_valid, in0_valid};
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign in_last    = {in1_last, in0_last};

  // The UART needs two quiet cycles after every strobe before the next one.
  assign tx_ok = !uart_active && !uart_dv && !dv_hist;

  assign busy  = (state != IDLE);
  assign ovf   = {ovf_r[1], ovf_r[0]};
  assign drop0 = drop_cnt[0];
  assign drop1 = drop_cnt[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign empty[p] = (wr_ptr[p] == rd_ptr[p]);
    assign full[p]  = (wr_ptr[p][AW] != rd_ptr[p][AW]) &&
                      (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
    // Fullness is judged at cycle start, so a same-cycle pop never makes room.
    assign push[p]  = in_valid[p] && !full[p] && !reset;
    assign pop[p]   = (state == DATA) && tx_ok && (grant == 1'(p)) && !empty[p];
    assign head[p]  = mem[p][rd_ptr[p][AW-1:0]];

    // FIFO storage write; contents need no reset since pointers gate them.
    always_ff @(posedge clk) begin
      if (push[p]) mem[p][wr_ptr[p][AW-1:0]] <= {in_last[p], in_data[p]};
    end

    // Read/write pointers, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end else begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
      end
    end

    // Sticky overflow flag and saturating dropped-byte counter.
    always_ff @(posedge clk) begin
      if (reset) begin
        ovf_r[p]    <= 1'b0;
        drop_cnt[p] <= '0;
      end else if (in_valid[p] && full[p]) begin
        ovf_r[p] <= 1'b1;
        if (drop_cnt[p] != 8'hFF) drop_cnt[p] <= drop_cnt[p] + 8'd1;
      end
    end
  end

  // Strobe history for the holdoff window.
  always_ff @(posedge clk) begin
    if (reset) dv_hist <= 1'b0;
    else       dv_hist <= uart_dv;
  end

  // Frame scheduler: pick a port, send its header, then drain one frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= 1'b0;
      uart_d  <= 8'h00;
      uart_dv <= 1'b0;
    end else begin
      uart_dv <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty[0] && !empty[1]) begin
            grant <= ~grant;
            state <= HDR;
          end else if (!empty[0]) begin
            grant <= 1'b0;
            state <= HDR;
          end else if (!empty[1]) begin
            grant <= 1'b1;
            state <= HDR;
          end
        end
        HDR: begin
          if (tx_ok) begin
            uart_d  <= 8'hA0 | {7'd0, grant};
            uart_dv <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          // An empty granted FIFO simply stalls here; the frame is never split.
          if (tx_ok && !empty[grant]) begin
            uart_d  <= head[grant][7:0];
            uart_dv <= 1'b1;
            if (head[grant][8]) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: directed frames with a scoreboard of expected
// UART bytes, checked by an independent monitor on every uart_dv strobe.
module tb_uart_tx_sched;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       in0_valid, in0_last, in1_valid, in1_last;
  logic [7:0] in0_data, in1_data;
  logic       uart_active;
  logic [7:0] uart_d;
  logic       uart_dv, grant, busy;
  logic [1:0] ovf;
  logic [7:0] drop0, drop1;

  uart_tx_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last),
    .uart_active(uart_active),
    .uart_d(uart_d), .uart_dv(uart_dv), .grant(grant), .busy(busy),
    .ovf(ovf), .drop0(drop0), .drop1(drop1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_stamp = -100;
  logic [7:0] exp_q[$];
  int stamps[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every strobe pops the next expected byte and checks spacing.
  always @(negedge clk) begin
    if (reset) begin
      last_stamp = -100;
    end else if (uart_dv) begin
      stamps.push_back(cyc);
      check("strobe_spacing_ge3", 32'(cyc - last_stamp >= 3), 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got uart_d 0x%0h, expected no strobe (cycle %0d)", uart_d, cyc);
      end else begin
        check("uart_d", 32'(uart_d), 32'(exp_q.pop_front()));
      end
      last_stamp = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int port, input logic [7:0] d, input logic l);
    if (port == 0) begin in0_valid = 1'b1; in0_data = d; in0_last = l; end
    else           begin in1_valid = 1'b1; in1_data = d; in1_last = l; end
    tick(1);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  task automatic push_both(input logic [7:0] d0, input logic [7:0] d1, input logic l);
    in0_valid = 1'b1; in0_data = d0; in0_last = l;
    in1_valid = 1'b1; in1_data = d1; in1_last = l;
    tick(1);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 2000) begin
      tick(1);
      k++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_strobes(input string name, input int n);
    int seen, k;
    seen = 0;
    k = 0;
    while (seen < n && k < 500) begin
      @(negedge clk);
      if (uart_dv) seen++;
      k++;
    end
    check({name, "_strobe_seen"}, 32'(seen), 32'(n));
  endtask

  initial begin
    int f;
    reset = 1'b1;
    in0_valid = 1'b1; in0_data = 8'hEE; in0_last = 1'b1;
    in1_valid = 1'b0; in1_data = 8'h00; in1_last = 1'b0;
    uart_active = 1'b0;
    tick(3);
    reset = 1'b0;
    in0_valid = 1'b0;

    // Reset state; strobes during reset must not have been stored.
    check("rst_uart_dv", 32'(uart_dv), 32'd0);
    check("rst_uart_d", 32'(uart_d), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_drop0", 32'(drop0), 32'd0);
    check("rst_drop1", 32'(drop1), 32'd0);
    tick(10);
    check("rst_ignored_input", 32'(busy), 32'd0);

    // Single frame on port 0, UART idle: strobes exactly 3 cycles apart.
    stamps.delete();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b1);
    drain("p0_frame");
    check("p0_frame_grant", 32'(grant), 32'd0);
    check("p0_frame_nstrobes", 32'(stamps.size()), 32'd4);
    if (stamps.size() == 4) begin
      for (int i = 1; i < 4; i++) check("p0_frame_gap3", 32'(stamps[i] - stamps[i-1]), 32'd3);
    end

    // Both ports in the same cycle: port 1 wins (grant was 0), no interleave.
    exp_q.push_back(8'hA1); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    push_both(8'h51, 8'h61, 1'b0);
    push_both(8'h52, 8'h62, 1'b1);
    drain("rr");
    check("rr_grant", 32'(grant), 32'd0);

    // UART busy for 50 cycles after the header: data strobe right after it falls.
    stamps.delete();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h71);
    push(0, 8'h71, 1'b1);
    wait_strobes("active_hdr", 1);
    tick(1);
    uart_active = 1'b1;
    tick(50);
    uart_active = 1'b0;
    f = cyc;
    drain("active");
    check("active_nstrobes", 32'(stamps.size()), 32'd2);
    if (stamps.size() == 2) check("active_release_cycle", 32'(stamps[1]), 32'(f + 1));

    // Port 0 frame with a gap: scheduler stalls in DATA; port 1 waits.
    stamps.delete();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h81); exp_q.push_back(8'h82);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h91);
    push(0, 8'h81, 1'b0);
    tick(5);
    push(1, 8'h91, 1'b1);
    tick(14);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_grant", 32'(grant), 32'd0);
    check("stall_nstrobes", 32'(stamps.size()), 32'd2);
    push(0, 8'h82, 1'b1);
    drain("stall");
    check("stall_grant_end", 32'(grant), 32'd1);

    // Overflow on port 1 with the UART held busy.
    uart_active = 1'b1;
    for (int i = 0; i < DEPTH + 5; i++) push(1, 8'(i), 1'b0);
    check("ovf_flags", 32'(ovf), 32'b10);
    check("ovf_drop1", 32'(drop1), 32'd5);
    check("ovf_drop0", 32'(drop0), 32'd0);
    for (int i = 0; i < 300; i++) push(1, 8'(i), 1'b0);
    check("ovf_drop1_sat", 32'(drop1), 32'd255);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    uart_active = 1'b0;
    check("ovf_rst_flags", 32'(ovf), 32'd0);
    check("ovf_rst_drop1", 32'(drop1), 32'd0);
    tick(20);
    check("ovf_rst_fifo_empty", 32'(busy), 32'd0);

    // Reset mid-frame: no further bytes, next frame starts with a header.
    exp_q.push_back(8'hA1); exp_q.push_back(8'hC1);
    push(1, 8'hC1, 1'b0);
    push(1, 8'hC2, 1'b0);
    push(1, 8'hC3, 1'b1);
    wait_strobes("midrst", 2);
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("midrst_uart_dv", 32'(uart_dv), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_drop1", 32'(drop1), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    tick(15);
    check("midrst_fifo_empty", 32'(busy), 32'd0);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hD1);
    push(0, 8'hD1, 1'b1);
    drain("midrst_new");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter DEPTH, default 64, per-port FIFO entries; SHALL be a power of two, 4..256.
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in0_valid, in1_valid  input  1 each  byte strobe from MII receiver N, one byte per high cycle.
REQ-005 in0_data, in1_data  input  8 each  received byte, qualified by inN_valid.
REQ-006 in0_last, in1_last  input  1 each  marks the final byte of a frame, qualified by inN_valid.
REQ-007 uart_active  input  1  UART transmitter busy.
REQ-008 uart_d  output  8  byte to UART.
REQ-009 uart_dv  output  1  one-cycle strobe qualifying uart_d.
REQ-010 grant  output  1  port currently or most recently served.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 ovf  output  2  sticky per-port overflow flags; bit N is port N.
REQ-013 drop0, drop1  output  8 each  saturating per-port dropped-byte counters.

Function
REQ-014 Each port SHALL own a DEPTH x 9 FIFO storing {last, data}, with pointers one bit wider than log2(DEPTH).
REQ-015 Push: inN_valid with the FIFO not full at cycle start SHALL write one entry; there is no backpressure toward the receivers.
REQ-016 Push to a full FIFO SHALL drop the byte, set ovf[N], and increment dropN, saturating at 255; a pop in the same cycle SHALL NOT rescue it.
REQ-017 A simultaneous push and pop on one FIFO SHALL both take effect; occupancy is unchanged.
REQ-018 Pointer wrap SHALL be modulo 2*DEPTH; full = MSBs differ and the rest match; empty = pointers equal.
REQ-019 tx_ok SHALL be true when uart_active==0 and uart_dv was low in both of the two previous cycles.
REQ-020 FSM states: IDLE, HDR, DATA.
REQ-021 IDLE: when one or more FIFOs are non-empty, the FSM SHALL select a port and go to HDR next cycle.
REQ-022 IDLE selection: if both FIFOs are non-empty, pick the port != grant (round-robin); otherwise pick the non-empty one.
REQ-023 HDR: on tx_ok, uart_d = 8'hA0 | port and uart_dv = 1 for one cycle, then go to DATA.
REQ-024 DATA: on tx_ok with the granted FIFO non-empty, pop one entry and output its data with uart_dv = 1 for one cycle.
REQ-025 DATA: if the popped entry has last = 1, go to IDLE in the same transition; otherwise stay in DATA.
REQ-026 DATA with the granted FIFO empty SHALL stall indefinitely; the other port SHALL NOT be served mid-frame.
REQ-027 uart_d SHALL hold its value between strobes.
REQ-028 Minimum spacing between uart_dv strobes SHALL be 3 cycles.
REQ-029 Header-to-first-data latency SHALL be 3 cycles when the UART is idle and data is present.
REQ-030 Arbitration SHALL be frame-granular: frames from the two ports are never interleaved.

Reset
REQ-031 Reset SHALL set FIFO pointers, ovf, drop0, drop1, grant, uart_d, uart_dv and the holdoff history to 0, and the FSM to IDLE.
REQ-032 A frame in progress at reset SHALL be abandoned, with no further bytes emitted.
REQ-033 Input strobes during reset SHALL be ignored.

Verification
REQ-034 Port 0 frame 11,22,33 (last on 33), UART always idle -> uart_d sequence A0,11,22,33; strobes 3 cycles apart; busy then low; grant = 0.
REQ-035 Both ports each push a 2-byte frame in the same cycle after reset -> A1,p1b0,p1b1 then A0,p0b0,p0b1, with no interleave.
REQ-036 Port 1 pushes DEPTH+5 bytes with uart_active held high -> ovf = 2'b10, drop1 = 5, drop0 = 0; 300 extra bytes -> drop1 = 255.
REQ-037 Port 0 frame body gaps: 1 byte, then 20 empty cycles, then the last byte -> FSM stalls in DATA; port 1 data pending meanwhile is emitted only after port 0's last byte.
REQ-038 uart_active held high for 50 cycles after a strobe -> next strobe occurs no earlier than the cycle after uart_active falls.
REQ-039 Reset asserted mid-frame -> uart_dv = 0, busy = 0, FIFOs empty, counters 0; a subsequent new frame starts with a header.
